// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared state encoding and default sizes for the scan controller
package seq_scan_pkg;

  localparam int W_DEF    = 8;
  localparam int PLEN_DEF = 4;
  localparam int CW_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - word handshake between producer and scan controller
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/seq_match.sv
// rtl/seq_match.sv - bit-serial overlapping pattern matcher with saturating match counter
module seq_match
  import seq_scan_pkg::*;
#(
  parameter int PLEN = PLEN_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            bit_en,
  input  logic            bit_in,
  input  logic [PLEN-1:0] pattern,
  output logic            match,
  output logic [CW-1:0]   match_cnt
);

  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] hist_q, hist_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic            match_q, match_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bit_en) begin
      hist_d  = PLEN'({hist_q, bit_in});
      fill_d  = (fill_q == FW'(PLEN)) ? fill_q : fill_q + FW'(1);
      // fill gate keeps a partly-filled history from matching an all-zero pattern
      match_d = (fill_d == FW'(PLEN)) && (hist_d == pattern);
      if (match_d && (cnt_q != '1)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word-to-bit scan sequencer feeding the serial pattern matcher
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int PLEN = PLEN_DEF,
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PLEN-1:0] pattern,
  seq_scan_ctrl_if.slave  in_if,
  output logic            busy,
  output logic            bit_out,
  output logic            match,
  output logic [CW-1:0]   match_cnt,
  output logic            done
);

  localparam int IW = $clog2(W);

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic [PLEN-1:0] pat_q, pat_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bit_out_q, bit_out_d;
  logic            clr, bit_en;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    last_d     = last_q;
    pat_d      = pat_q;
    in_ready_d = in_ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bit_out_d  = 1'b0;
    clr        = 1'b0;
    bit_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          pat_d      = pattern;
          clr        = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      LOAD: begin
        if (in_if.in_valid) begin
          state_d    = SHIFT;
          bit_out_d  = in_if.in_data[W-1];
          word_d     = {in_if.in_data[W-2:0], 1'b0};
          last_d     = in_if.in_last;
          idx_d      = IW'(W - 1);
          in_ready_d = 1'b0;
        end
      end
      SHIFT: begin
        // bit_out_q is the bit on the wire this cycle; word_q holds the remaining bits MSB-aligned
        bit_en = 1'b1;
        if (idx_q == '0) begin
          if (last_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = LOAD;
            in_ready_d = 1'b1;
          end
        end else begin
          idx_d     = idx_q - IW'(1);
          bit_out_d = word_q[W-1];
          word_d    = {word_q[W-2:0], 1'b0};
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      pat_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bit_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      pat_q      <= pat_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bit_out_q  <= bit_out_d;
    end
  end

  seq_match #(
    .PLEN (PLEN),
    .CW   (CW)
  ) u_match (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bit_en    (bit_en),
    .bit_in    (bit_out_q),
    .pattern   (pat_q),
    .match     (match),
    .match_cnt (match_cnt)
  );

  assign in_if.in_ready = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bit_out        = bit_out_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - scoreboard bench for seq_scan_ctrl (full and 2-bit saturating counters)
module tb_seq_scan_ctrl;
  import seq_scan_pkg::*;

  localparam int W    = 8;
  localparam int PLEN = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            start;
  logic [PLEN-1:0] pattern;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_last;

  logic       busy, bit_out, match, done;
  logic [7:0] match_cnt;
  logic       busy_s, bit_out_s, match_s, done_s;
  logic [1:0] match_cnt_s;

  seq_scan_ctrl_if #(.W(W)) bus ();
  seq_scan_ctrl_if #(.W(W)) bus_s ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.in_last    = in_last;
  assign bus_s.in_valid = in_valid;
  assign bus_s.in_data  = in_data;
  assign bus_s.in_last  = in_last;

  seq_scan_ctrl #(.W(W), .PLEN(PLEN), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .in_if     (bus),
    .busy      (busy),
    .bit_out   (bit_out),
    .match     (match),
    .match_cnt (match_cnt),
    .done      (done)
  );

  seq_scan_ctrl #(.W(W), .PLEN(PLEN), .CW(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .in_if     (bus_s),
    .busy      (busy_s),
    .bit_out   (bit_out_s),
    .match     (match_s),
    .match_cnt (match_cnt_s),
    .done      (done_s)
  );

  typedef struct {
    logic [15:0] mask;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: records match positions per scan and scores them when done pulses
  int          shift_cnt = 0;
  logic [15:0] mask = '0;
  bit          pend = 1'b0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      shift_cnt = 0;
      mask      = '0;
      pend      = 1'b0;
    end else begin
      check("sat_shadow", {busy_s, bit_out_s, match_s, done_s, bus_s.in_ready},
            {busy, bit_out, match, done, bus.in_ready});
      if (pend) begin
        check("busy_fall", {busy, done}, 2'b00);
        pend = 1'b0;
      end
      if (match) begin
        if (shift_cnt >= 1 && shift_cnt <= 16) mask[shift_cnt-1] = 1'b1;
        else check("match_pos", shift_cnt, 0);
      end
      if (busy && !bus.in_ready && !done) shift_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("match_mask", mask, e.mask);
          check("match_cnt", match_cnt, e.cnt);
          check("match_cnt_sat", match_cnt_s, (e.cnt > 3) ? 3 : e.cnt);
        end
        pend      = 1'b1;
        shift_cnt = 0;
        mask      = '0;
      end else if (!busy) begin
        shift_cnt = 0;
        mask      = '0;
      end
    end
  end

  task automatic do_start(input logic [PLEN-1:0] p, input logic with_valid);
    @(negedge clk);
    start    = 1'b1;
    pattern  = p;
    in_valid = with_valid;
    in_data  = 8'hA5;
    in_last  = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("load_after_start", {busy, bus.in_ready, match_cnt}, {2'b11, 8'h00});
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("ready_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    check("ready_low_in_shift", bus.in_ready, 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
  endtask

  task automatic run(input logic [PLEN-1:0] p, input logic [W-1:0] w0, input logic [W-1:0] w1,
                     input int nw, input logic [15:0] m, input int c, input logic with_valid);
    exp_q.push_back('{m, c});
    do_start(p, with_valid);
    send_word(w0, nw == 1);
    if (nw == 2) send_word(w1, 1'b1);
    wait_idle();
  endtask

  int n;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, bit_out, match, done, bus.in_ready, match_cnt}, 0);
    rst = 1'b0;

    // single word, start with in_valid asserted in IDLE
    run(4'b1001, 8'b1001_0010, 8'h00, 1, 16'h0048, 2, 1'b1);
    repeat (3) @(negedge clk);
    check("cnt_hold_idle", {busy, match_cnt}, {1'b0, 8'd2});

    // match spanning a word boundary
    run(4'b1001, 8'b0000_0100, 8'b1000_0000, 2, 16'h0100, 1, 1'b0);

    // saturation in the 2-bit instance
    run(4'b1111, 8'hFF, 8'hFF, 2, 16'hFFF8, 13, 1'b0);

    // producer stall in LOAD
    exp_q.push_back('{16'h0480, 2});
    do_start(4'b1001, 1'b0);
    send_word(8'b0000_1001, 1'b0);
    n = 1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("word_cadence", n, W + 1);
    repeat (5) begin
      check("stall", {bus.in_ready, bit_out, match_cnt}, {1'b1, 1'b0, 8'd1});
      @(negedge clk);
    end
    send_word(8'b0010_0000, 1'b1);
    wait_idle();

    // asynchronous reset during bit index 3 of the first word
    do_start(4'b1001, 1'b0);
    send_word(8'b1001_0000, 1'b1);
    repeat (4) @(negedge clk);
    check("pre_reset", {busy, match, match_cnt}, {2'b11, 8'd1});
    #2 rst = 1'b1;
    #1 check("async_reset", {busy, bit_out, match, done, bus.in_ready, match_cnt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(4'b0100, 8'b0100_0000, 8'h00, 1, 16'h0008, 1, 1'b0);

    // start and pattern change while shifting are ignored
    exp_q.push_back('{16'h0048, 2});
    do_start(4'b1001, 1'b0);
    send_word(8'b1001_0010, 1'b1);
    @(negedge clk);
    start   = 1'b1;
    pattern = 4'b0010;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    pattern = '0;

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller for the serial pattern detector. It accepts parallel words over a valid/ready handshake and serializes them MSB-first, one bit per cycle, into a programmable-pattern detector. It counts overlapping matches across word boundaries and reports a saturating match count with a done pulse. It sits between a word-oriented producer (bus or FIFO) and the bit-serial detector datapath, and is the sequencing layer for that datapath.

## Interface
- W, 8, input word width (≥2)
- PLEN, 4, pattern length in bits (1..W)
- CW, 8, match-count width
- clk  in  1  clock; all state updates on posedge clk
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin scan; honoured only in IDLE
- pattern  in  PLEN  pattern to detect; latched on accepted start; bit PLEN-1 is the oldest bit
- in_valid  in  1  word available
- in_data  in  W  word; bit W-1 is shifted first
- in_last  in  1  qualifies in_data as the final word of the scan
- in_ready  out  1  word accepted when in_valid && in_ready
- busy  out  1  state != IDLE
- bit_out  out  1  bit currently presented to the detector (0 when not in SHIFT)
- match  out  1  registered; high for the cycle after a bit completes the pattern
- match_cnt  out  CW  matches this scan; saturates at all-ones
- done  out  1  one-cycle pulse at end of scan

## Operation
- States:
  - IDLE: start → LOAD; clears history, fill counter and match_cnt; latches pattern.
  - LOAD: in_ready=1; on handshake, capture in_data/in_last → SHIFT.
  - SHIFT: W cycles, bit index W-1 down to 0.
    - After bit 0: → DONE if captured last, else → LOAD.
  - DONE: done=1 → IDLE.
- Detector history: PLEN-bit shift register plus fill counter saturating at PLEN.
  - Each SHIFT cycle shifts bit_out in at the LSB.
  - On the same edge, match ← (fill_next==PLEN && hist_next==pattern_latched), and match_cnt increments on match unless saturated.
- Overlapping matches count: pattern 1001 in stream 1001001 → 2.
- History persists across words within a scan and is cleared only by accepted start or rst.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside LOAD.
  - pattern changes after latch.
- match_cnt holds its value in IDLE after DONE until the next accepted start.

## Timing
- Reset value of every output: in_ready=0, busy=0, bit_out=0, match=0, match_cnt=0, done=0; state IDLE. Reset takes effect immediately, including mid-scan (no done pulse).
- start sampled at edge t → LOAD (in_ready=1) from t+1.
- Handshake at edge h → bit W-1 on bit_out in cycles h+1 … bit 0 in cycle h+W → LOAD (or DONE) at h+W+1.
- Throughput: W+1 cycles per word with a continuously valid producer; in_ready is never high in SHIFT.
- match/match_cnt lag bit_out by one cycle. In the DONE cycle, match reflects the final bit and match_cnt is final.
- Holding in_valid low in LOAD stalls indefinitely; detector state is unchanged.
- Simultaneous start and in_valid in IDLE: only start is acted on; no word is accepted.

## Structure
- Shared package seq_scan_pkg holds:
  - State typedef (IDLE, LOAD, SHIFT, DONE; 2-bit encoding).
  - Default values of W, PLEN, CW.
- Sub-module seq_match contains the history register, fill counter, compare, registered match and saturating counter. It takes clk, rst, clr, bit_en, bit_in and pattern. The controller owns the FSM, word register and bit index.

## Test plan
- Reset, start, pattern=4'b1001, single word 8'b1001_0010 with in_last → match high after bits 4 and 7; match_cnt=2 in DONE; done high exactly 1 cycle; busy falls the next cycle.
- Cross-word match, pattern=4'b1001: words 8'b0000_0100 then 8'b1000_0000 (last) → exactly 1 match, raised the cycle after the first bit of word 2; match_cnt=1.
- in_valid low for 5 cycles in LOAD → in_ready stays 1, bit_out=0, match_cnt unchanged; the next handshake proceeds with normal W+1 cadence.
- CW=2, pattern=4'b1111, words 8'hFF, 8'hFF (last) → 13 raw matches; match_cnt saturates at 2'b11.
- rst asserted mid-SHIFT (bit 3 of word 1) → all outputs 0 immediately without waiting for an edge, no done pulse; a fresh start then scans correctly from an empty history.
- start pulsed and pattern changed during SHIFT → no effect: no restart, count uses the originally latched pattern.
